// File: rtl/ravenoc_pkg.sv
// ---------------------------------------------------------------------------
// ravenoc_pkg
// Shared types and constants for the RaveNoC router blocks.
//   arb_state_t : wormhole arbiter FSM states (ARB_IDLE, ARB_LOCKED)
//   ARB_N_REQ   : candidate inputs per router output port
// ---------------------------------------------------------------------------
package ravenoc_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int ARB_N_REQ = 4;

endpackage : ravenoc_pkg

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: selects the first set bit of req_i at or
// after ptr_i, searching upward and wrapping past N_REQ-1 back to 0. The wrap
// is done explicitly so non-power-of-two N_REQ works.
// Ports:
//   req_i  [N_REQ] : request vector
//   ptr_i  [IDX_W] : highest-priority position (must be < N_REQ)
//   gnt_o  [N_REQ] : one-hot winner (0 when no request)
//   idx_o  [IDX_W] : binary index of the winner (0 when no request)
//   any_o          : at least one request present
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int pos;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!any_o && req_i[IDX_W'(pos)]) begin
        any_o                 = 1'b1;
        gnt_o[IDX_W'(pos)]    = 1'b1;
        idx_o                 = IDX_W'(pos);
      end
    end
  end

endmodule : rr_priority_picker

// File: rtl/ravenoc_wh_arbiter.sv
// ---------------------------------------------------------------------------
// ravenoc_wh_arbiter
// Wormhole round-robin arbiter for one router output port. A packet's grant
// is taken on its head flit and held until its tail flit transfers; only the
// winner sees the downstream ready.
//
// Handshake: a flit transfers on a requester when valid_i[n] & ready_o[n];
// ready_o is ready_i masked by the grant, so a non-granted requester never
// sees ready and must hold its flit. valid_o mirrors the winner's valid.
//
// Optional feature: define RAVENOC_ARB_WDOG_EN to build the stall watchdog
// (wdog_err_o sets sticky after WDOG_CYCLES locked cycles without transfer).
// Without it wdog_err_o is tied to 0.
//
// Ports:
//   clk, arst (async, active-low)
//   valid_i/head_i/tail_i [N_REQ] : per-requester flit qualifiers
//   ready_i                       : downstream accepts a flit
//   grant_o [N_REQ], grant_idx_o  : one-hot / binary grant
//   valid_o                       : valid of the granted requester
//   ready_o [N_REQ]               : grant_o & ready_i
//   locked_o                      : mid-packet
//   wdog_err_o                    : sticky watchdog error
//   dbg_state_o, dbg_prio_ptr_o   : FSM state and round-robin pointer
// ---------------------------------------------------------------------------
module ravenoc_wh_arbiter
  import ravenoc_pkg::*;
#(
  parameter int N_REQ       = ARB_N_REQ,
  parameter int WDOG_CYCLES = 256,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N_REQ-1:0] valid_i,
  input  logic [N_REQ-1:0] head_i,
  input  logic [N_REQ-1:0] tail_i,
  input  logic             ready_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             valid_o,
  output logic [N_REQ-1:0] ready_o,
  output logic             locked_o,
  output logic             wdog_err_o,
  output arb_state_t       dbg_state_o,
  output logic [IDX_W-1:0] dbg_prio_ptr_o
);

  arb_state_t       state_q,    state_d;
  logic [IDX_W-1:0] prio_ptr_q, prio_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             lock_xfer;

  // Explicit wrap so the pointer never lands on an unused code.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= N_REQ - 1) return '0;
    else                        return idx + 1'b1;
  endfunction

  // Only head flits may open a packet; a stray body/tail in IDLE is ignored.
  assign cand = valid_i & head_i;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i (cand),
    .ptr_i (prio_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign lock_xfer = valid_i[lock_idx_q] & ready_i;

  always_comb begin
    state_d     = state_q;
    prio_ptr_d  = prio_ptr_q;
    lock_idx_d  = lock_idx_q;
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        grant_o     = pick_gnt;
        grant_idx_o = pick_idx;
        valid_o     = pick_any;
        if (pick_any) begin
          // Single-flit packet that transfers now never needs the lock.
          if (ready_i && tail_i[pick_idx]) begin
            prio_ptr_d = next_idx(pick_idx);
          end else begin
            lock_idx_d = pick_idx;
            state_d    = ARB_LOCKED;
          end
        end
      end
      ARB_LOCKED: begin
        // Grant decodes from the registered owner; other requesters cannot
        // disturb it, and a dropped valid does not release it.
        grant_o[lock_idx_q] = 1'b1;
        grant_idx_o         = lock_idx_q;
        valid_o             = valid_i[lock_idx_q];
        if (lock_xfer && tail_i[lock_idx_q]) begin
          prio_ptr_d = next_idx(lock_idx_q);
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= ARB_IDLE;
      prio_ptr_q <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign ready_o        = grant_o & {N_REQ{ready_i}};
  assign locked_o       = (state_q == ARB_LOCKED);
  assign dbg_state_o    = state_q;
  assign dbg_prio_ptr_o = prio_ptr_q;

`ifdef RAVENOC_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q, wdog_err_d;

  // Count locked cycles with no transfer; saturate at the limit so the
  // counter cannot wrap while the grant stays stuck.
  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == ARB_LOCKED && !lock_xfer) begin
      if (wdog_cnt_q == CNT_W'(WDOG_CYCLES)) wdog_cnt_d = wdog_cnt_q;
      else                                   wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
    wdog_err_d = wdog_err_q | (wdog_cnt_d == CNT_W'(WDOG_CYCLES));
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err_o = wdog_err_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES > 0);
  assign wdog_err_o      = 1'b0;
`endif

endmodule : ravenoc_wh_arbiter

// File: tb/tb_ravenoc_wh_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ravenoc_wh_arbiter
// Bench for the wormhole arbiter: directed packet scenarios followed by
// randomized traffic, checked against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_ravenoc_wh_arbiter;
  import ravenoc_pkg::*;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int WD   = 8;
  // {grant, idx, valid, ready, locked, err, ptr}
  localparam int EXP_W = N + IW + 1 + N + 1 + 1 + IW;

  logic          clk;
  logic          arst;
  logic [N-1:0]  valid_i, head_i, tail_i;
  logic          ready_i;
  logic [N-1:0]  grant_o;
  logic [IW-1:0] grant_idx_o;
  logic          valid_o;
  logic [N-1:0]  ready_o;
  logic          locked_o;
  logic          wdog_err_o;
  arb_state_t    dbg_state_o;
  logic [IW-1:0] dbg_prio_ptr_o;

  ravenoc_wh_arbiter #(
    .N_REQ       (N),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .valid_i        (valid_i),
    .head_i         (head_i),
    .tail_i         (tail_i),
    .ready_i        (ready_i),
    .grant_o        (grant_o),
    .grant_idx_o    (grant_idx_o),
    .valid_o        (valid_o),
    .ready_o        (ready_o),
    .locked_o       (locked_o),
    .wdog_err_o     (wdog_err_o),
    .dbg_state_o    (dbg_state_o),
    .dbg_prio_ptr_o (dbg_prio_ptr_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner = -1 means no packet in flight.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  logic m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] h,
                       input logic [N-1:0] t, input logic r, input logic rst);
    logic [N-1:0]  g;
    logic [IW-1:0] idx;
    logic          vo;
    int            w;
    @(posedge clk);
    #1;
    arst    = ~rst;
    valid_i = v;
    head_i  = h;
    tail_i  = t;
    ready_i = r;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    end
    g = '0; idx = '0; vo = 1'b0; w = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (w < 0 && v[p] && h[p]) w = p;
      end
      if (w >= 0) begin
        g[w] = 1'b1; idx = IW'(w); vo = 1'b1;
      end
    end else begin
      g[m_owner] = 1'b1; idx = IW'(m_owner); vo = v[m_owner];
    end
    exp_q.push_back({g, idx, vo, (r ? g : {N{1'b0}}), (m_owner >= 0), m_err, IW'(m_ptr)});

    // Advance the model to the state it holds after the coming clock edge.
    if (!rst) begin
      if (m_owner < 0) begin
        m_cnt = 0;
        if (w >= 0) begin
          if (r && t[w]) m_ptr = (w + 1) % N;
          else           m_owner = w;
        end
      end else if (v[m_owner] && r) begin
        m_cnt = 0;
        if (t[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else begin
`ifdef RAVENOC_ARB_WDOG_EN
        if (m_cnt < WD) m_cnt++;
        if (m_cnt == WD) m_err = 1'b1;
`endif
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_o",     32'(grant_o),     32'(e[EXP_W-1 -: N]));
        chk("grant_idx_o", 32'(grant_idx_o), 32'(e[EXP_W-N-1 -: IW]));
        chk("valid_o",     32'(valid_o),     32'(e[EXP_W-N-IW-1]));
        chk("ready_o",     32'(ready_o),     32'(e[EXP_W-N-IW-2 -: N]));
        chk("locked_o",    32'(locked_o),    32'(e[IW+1]));
        chk("state",       32'(dbg_state_o), 32'(e[IW+1]));
        chk("wdog_err_o",  32'(wdog_err_o),  32'(e[IW]));
        chk("prio_ptr",    32'(dbg_prio_ptr_o), 32'(e[IW-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    arst = 1'b0; valid_i = '0; head_i = '0; tail_i = '0; ready_i = 1'b0;
    cycle('0, '0, '0, 1'b0, 1'b1);
    cycle('0, '0, '0, 1'b0, 1'b1);

    // single-flit packet on requester 2
    cycle(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b0);

    // round-robin order from pointer 0
    cycle('0, '0, '0, 1'b0, 1'b1);
    repeat (5) cycle(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0);

    // wormhole hold: requester 1 head/body/tail, requester 0 waits
    cycle('0, '0, '0, 1'b0, 1'b1);
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0011, 4'b0001, 4'b0010, 1'b1, 1'b0);
    cycle(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0);

    // backpressure on requester 3 while requester 0 requests
    cycle('0, '0, '0, 1'b0, 1'b1);
    cycle(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
    repeat (5) cycle(4'b1001, 4'b1001, 4'b0000, 1'b0, 1'b0);
    cycle(4'b1001, 4'b0001, 4'b1000, 1'b1, 1'b0);
    cycle(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0);

    // reset mid-packet on requester 2
    cycle(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1);
    cycle(4'b0101, 4'b0101, 4'b0101, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0);

    // long stall with valid dropped, then tail
    cycle(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0);
    repeat (WD + 3) cycle('0, '0, '0, 1'b1, 1'b0);
    cycle(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0);
    repeat (2) cycle('0, '0, '0, 1'b1, 1'b0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] v, h, t;
      for (int b = 0; b < N; b++) begin
        v[b] = ($urandom_range(0, 9) < 7);
        h[b] = ($urandom_range(0, 9) < 4);
        t[b] = ($urandom_range(0, 9) < 4);
      end
      cycle(v, h, t, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
    end
    cycle('0, '0, '0, 1'b0, 1'b0);

    // let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ravenoc_wh_arbiter
